// File: rtl/mux_scan_ctrl_pkg.sv
// Shared types and constants for the mux scan controller.
package mux_scan_pkg;

    localparam int unsigned CNT_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_SAMPLE = 2'd2
    } state_e;

    // Legal build: power-of-two channel count 2..256, settle time 1..15 cycles.
    function automatic bit params_ok(input int unsigned n_ch, input int unsigned settle);
        return (n_ch >= 32'd2) && (n_ch <= 32'd256) && ((n_ch & (n_ch - 32'd1)) == 32'd0)
            && (settle >= 32'd1) && (settle <= 32'd15);
    endfunction

endpackage

// File: rtl/mux_scan_ctrl_if.sv
// Host/mux-facing signal bundle of the scan controller.
interface mux_scan_ctrl_if #(
    parameter int unsigned N_CH = 8
);
    localparam int unsigned SEL_W = $clog2(N_CH);

    logic             start;
    logic             abort;
    logic             y;
    logic [SEL_W-1:0] sel;
    logic [N_CH-1:0]  data_out;
    logic             valid;
    logic             busy;

    modport master (
        output start, abort, y,
        input  sel, data_out, valid, busy
    );

    modport slave (
        input  start, abort, y,
        output sel, data_out, valid, busy
    );
endinterface

// File: rtl/mux_scan_ctrl_settle_timer.sv
// Free-running settle counter; cleared by clr_i, flags the last settle cycle.
module settle_timer
    import mux_scan_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    output logic tc_c
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = clr_i ? '0 : cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc_c = (cnt_q == CNT_W'(SETTLE_CYCLES - 1));

endmodule

// File: rtl/mux_scan_ctrl.sv
// Steps the mux select through every channel, samples y after a settle delay,
// and publishes the full scan as one word with a single-cycle valid pulse.
module mux_scan_ctrl
    import mux_scan_pkg::*;
#(
    parameter int unsigned N_CH          = 8,
    parameter int unsigned SETTLE_CYCLES = 1
) (
    input  logic           clk,
    input  logic           rst_n,
    mux_scan_ctrl_if.slave bus
);

    localparam int unsigned SEL_W = $clog2(N_CH);

    if (!params_ok(N_CH, SETTLE_CYCLES)) begin : g_param_chk
        $error("mux_scan_ctrl: illegal N_CH=%0d / SETTLE_CYCLES=%0d", N_CH, SETTLE_CYCLES);
    end

    state_e           state_q;
    state_e           state_d;
    logic [SEL_W-1:0] sel_q;
    logic [SEL_W-1:0] sel_d;
    logic [N_CH-1:0]  cap_q;
    logic [N_CH-1:0]  cap_d;
    logic [N_CH-1:0]  data_q;
    logic [N_CH-1:0]  data_d;
    logic             valid_q;
    logic             valid_d;
    logic             busy_q;
    logic             busy_d;
    logic             tc_c;
    logic             clr_c;
    logic             last_c;

    assign last_c = (sel_q == SEL_W'(N_CH - 1));

    // Counter only runs while settling; any other state or exit from SETTLE restarts it.
    assign clr_c = (state_q != ST_SETTLE) || tc_c || bus.abort;

    settle_timer #(
        .SETTLE_CYCLES(SETTLE_CYCLES)
    ) u_settle_timer (
        .clk  (clk),
        .rst_n(rst_n),
        .clr_i(clr_c),
        .tc_c (tc_c)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.start && !bus.abort) begin
                    state_d = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (bus.abort) begin
                    state_d = ST_IDLE;
                end else if (tc_c) begin
                    state_d = ST_SAMPLE;
                end
            end
            ST_SAMPLE: begin
                if (bus.abort || last_c) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_SETTLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Datapath next values; the published word is the capture buffer with the final bit merged in.
    always_comb begin
        sel_d   = sel_q;
        cap_d   = cap_q;
        data_d  = data_q;
        valid_d = 1'b0;
        busy_d  = (state_d != ST_IDLE);
        case (state_q)
            ST_IDLE: begin
                sel_d = '0;
            end
            ST_SETTLE: begin
                if (bus.abort) begin
                    sel_d = '0;
                    cap_d = '0;
                end
            end
            ST_SAMPLE: begin
                if (bus.abort) begin
                    sel_d = '0;
                    cap_d = '0;
                end else begin
                    cap_d[sel_q] = bus.y;
                    if (last_c) begin
                        data_d  = cap_d;
                        valid_d = 1'b1;
                        sel_d   = '0;
                    end else begin
                        sel_d = sel_q + SEL_W'(1);
                    end
                end
            end
            default: begin
                sel_d = '0;
                cap_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_q   <= '0;
            cap_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            sel_q   <= sel_d;
            cap_q   <= cap_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
        end
    end

    assign bus.sel      = sel_q;
    assign bus.data_out = data_q;
    assign bus.valid    = valid_q;
    assign bus.busy     = busy_q;

endmodule
